// File: rtl/denormalizer_pkg.sv
// Shared FPU constants and the exponent/fraction pair passed between
// the normalizer and the denormalizer.
package denormalizer_pkg;

   localparam int EXPONENT_WIDTH = 10;
   localparam int FRACTION_WIDTH = 49;
   localparam int MAX_SHIFT      = FRACTION_WIDTH;
   localparam int SHIFT_WIDTH    = $clog2(MAX_SHIFT + 1);

   typedef struct packed {
      logic signed [EXPONENT_WIDTH-1:0] exponent;
      logic [FRACTION_WIDTH-1:0]        fraction;
   } fp_norm_t;

endpackage

// File: rtl/denormalizer_if.sv
// Valid/ready operand and result bus of the denormalizer.
interface denormalizer_if;
   import denormalizer_pkg::*;

   logic                             in_valid;
   logic                             in_ready;
   logic signed [EXPONENT_WIDTH-1:0] normalized_exponent;
   logic [FRACTION_WIDTH-1:0]        normalized_fraction;
   logic                             out_valid;
   logic                             out_ready;
   logic signed [EXPONENT_WIDTH-1:0] denormal_exponent;
   logic [FRACTION_WIDTH-1:0]        denormal_fraction;
   logic                             denormal_sticky;
   logic                             denormal_flag;

   modport master (
      output in_valid, normalized_exponent, normalized_fraction, out_ready,
      input  in_ready, out_valid, denormal_exponent, denormal_fraction,
             denormal_sticky, denormal_flag
   );

   modport slave (
      input  in_valid, normalized_exponent, normalized_fraction, out_ready,
      output in_ready, out_valid, denormal_exponent, denormal_fraction,
             denormal_sticky, denormal_flag
   );

endinterface

// File: rtl/denormalizer_right_shifter.sv
// Combinational right shifter with sticky collection; counterpart of the
// normalizer's left shifter.
module denormalizer_right_shifter
   import denormalizer_pkg::*;
(
   input  logic [SHIFT_WIDTH-1:0]    shift_count_i,
   input  logic [FRACTION_WIDTH-1:0] operand_i,
   output logic [FRACTION_WIDTH-1:0] result_o,
   output logic                      sticky_o
);

   logic [FRACTION_WIDTH-1:0] lost_mask;

   always_comb begin
      // Bits below the shift point fall off the end; a full-width shift
      // clears the ones vector, so the mask covers every operand bit.
      lost_mask = ~({FRACTION_WIDTH{1'b1}} << shift_count_i);
      result_o  = operand_i >> shift_count_i;
      sticky_o  = |(operand_i & lost_mask);
   end

endmodule

// File: rtl/denormalizer.sv
// Two-stage valid/ready pipeline that right-shifts tiny normalized results
// into subnormal form ahead of rounding.
module denormalizer
   import denormalizer_pkg::*;
(
   input  logic           clk,
   input  logic           reset_n,
   denormalizer_if.slave  bus
);

   localparam logic signed [EXPONENT_WIDTH:0] ONE_EXT   = (EXPONENT_WIDTH+1)'(1);
   localparam logic signed [EXPONENT_WIDTH:0] SAT_LIMIT = (EXPONENT_WIDTH+1)'(MAX_SHIFT);

   logic s1_en, s2_en;

   // stage 1 state
   logic                     s1_valid_q;
   fp_norm_t                 s1_op_q;
   logic [SHIFT_WIDTH-1:0]   s1_shift_q, s1_shift_d;
   logic signed [EXPONENT_WIDTH:0] exp_ext, shift_wide;

   // stage 2 state
   logic                             s2_valid_q;
   logic signed [EXPONENT_WIDTH-1:0] s2_exp_q, s2_exp_d;
   logic [FRACTION_WIDTH-1:0]        s2_frac_q, s2_frac_d;
   logic                             s2_sticky_q, s2_sticky_d;
   logic                             s2_flag_q, s2_flag_d;

   assign s2_en        = !s2_valid_q || bus.out_ready;
   assign s1_en        = !s1_valid_q || s2_en;
   assign bus.in_ready = s1_en;

   // One extra bit keeps 1 - exp from wrapping at the most negative exponent.
   always_comb begin
      exp_ext    = {bus.normalized_exponent[EXPONENT_WIDTH-1], bus.normalized_exponent};
      shift_wide = ONE_EXT - exp_ext;
      if (!exp_ext[EXPONENT_WIDTH] && (exp_ext != '0))
         s1_shift_d = '0;
      else if (shift_wide > SAT_LIMIT)
         s1_shift_d = SHIFT_WIDTH'(MAX_SHIFT);
      else
         s1_shift_d = shift_wide[SHIFT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_op_q    <= '0;
         s1_shift_q <= '0;
      end else if (s1_en) begin
         s1_valid_q       <= bus.in_valid;
         s1_op_q.exponent <= bus.normalized_exponent;
         s1_op_q.fraction <= bus.normalized_fraction;
         s1_shift_q       <= s1_shift_d;
      end
   end

   denormalizer_right_shifter u_shifter (
      .shift_count_i (s1_shift_q),
      .operand_i     (s1_op_q.fraction),
      .result_o      (s2_frac_d),
      .sticky_o      (s2_sticky_d)
   );

   always_comb begin
      s2_flag_d = (s1_shift_q != '0);
      s2_exp_d  = s2_flag_d ? '0 : s1_op_q.exponent;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid_q  <= 1'b0;
         s2_exp_q    <= '0;
         s2_frac_q   <= '0;
         s2_sticky_q <= 1'b0;
         s2_flag_q   <= 1'b0;
      end else if (s2_en) begin
         s2_valid_q  <= s1_valid_q;
         s2_exp_q    <= s2_exp_d;
         s2_frac_q   <= s2_frac_d;
         s2_sticky_q <= s2_sticky_d;
         s2_flag_q   <= s2_flag_d;
      end
   end

   assign bus.out_valid         = s2_valid_q;
   assign bus.denormal_exponent = s2_exp_q;
   assign bus.denormal_fraction = s2_frac_q;
   assign bus.denormal_sticky   = s2_sticky_q;
   assign bus.denormal_flag     = s2_flag_q;

endmodule
